// File: rtl/snn_spike_scheduler.sv
// rtl/snn_spike_scheduler.sv - spike frame FIFO, per-timestep issue sequencer and output spike counters
//
// Purpose: buffers input spike frames from the loader and issues one frame to the SNN
// core per delay_clk timestep with a one-cycle snn_enable pulse. Output spikes of the
// core are sampled on the tick that follows an issue and accumulated into saturating
// per-neuron counters.
//
// Ports:
//   system_clock, reset          sole clock, synchronous active-high reset
//   frame_in/frame_valid/ready   loader side frame enqueue (ready = FIFO not full)
//   delay_clk                    timestep clock, synchronous to system_clock
//   run                          scheduler enable
//   clear_counts                 zeroes counters and the underrun flag
//   snn_input_spikes/snn_enable  frame and issue pulse towards the core
//   snn_output_spikes            output spikes from the core
//   spike_counts                 neuron i at [i*CNT_W +: CNT_W]
//   fifo_level, busy, underrun   status
//
// Optional feature macro: SCHED_UNDERRUN_HOLD_EN - on underrun the last issued frame is
// re-presented instead of an all-zero frame.

module snn_spike_scheduler #(
    parameter int FRAME_W = 16,
    parameter int DEPTH   = 4,
    parameter int OUT_N   = 2,
    parameter int CNT_W   = 8
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic [FRAME_W-1:0]       frame_in,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    input  logic                     delay_clk,
    input  logic                     run,
    input  logic                     clear_counts,
    output logic [FRAME_W-1:0]       snn_input_spikes,
    output logic                     snn_enable,
    input  logic [OUT_N-1:0]         snn_output_spikes,
    output logic [OUT_N*CNT_W-1:0]   spike_counts,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic                     underrun
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   dq_q;
    logic                   tick;
    logic                   launch;
    logic                   sample;
    logic                   issued_q;
    logic [FRAME_W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q;
    logic                   empty, full, push, pop;
    logic [FRAME_W-1:0]     spikes_q, spikes_d;
    logic [FRAME_W-1:0]     underrun_frame;
    logic                   underrun_q;
    logic [CNT_W-1:0]       cnt_q [OUT_N];

    // delay_clk already lives in the system_clock domain, so one register is enough
    // to find its rising edge.
    assign tick = delay_clk & ~dq_q;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));
    assign push  = frame_valid & ~full;
    assign pop   = launch & ~empty;

    // The frame and pop are committed on the tick edge so that the frame is already
    // on snn_input_spikes in the same cycle snn_enable is high (the ISSUE cycle).
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = ARMED;
            end
            ARMED: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (tick) begin
                    launch  = 1'b1;
                    sample  = issued_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = run ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SCHED_UNDERRUN_HOLD_EN
    assign underrun_frame = spikes_q;
`else
    assign underrun_frame = '0;
`endif

    always_comb begin
        spikes_d = spikes_q;
        if (launch) spikes_d = empty ? underrun_frame : mem_q[rd_ptr_q];
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q  <= IDLE;
            dq_q     <= 1'b0;
            issued_q <= 1'b0;
            spikes_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            dq_q     <= delay_clk;
            spikes_q <= spikes_d;
            // Sampling is only meaningful once a frame has been issued since the
            // last pass through IDLE.
            if (state_q == ISSUE)     issued_q <= 1'b1;
            else if (state_q == IDLE) issued_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge system_clock) begin
        if (push) mem_q[wr_ptr_q] <= frame_in;
    end

    // Clear has priority over a coinciding sampling tick.
    always_ff @(posedge system_clock) begin
        if (reset || clear_counts) begin
            underrun_q <= 1'b0;
            for (int i = 0; i < OUT_N; i++) cnt_q[i] <= '0;
        end else begin
            if (launch && empty) underrun_q <= 1'b1;
            if (sample) begin
                for (int i = 0; i < OUT_N; i++) begin
                    if (snn_output_spikes[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < OUT_N; g++) begin : g_cnt
        assign spike_counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign frame_ready      = ~full;
    assign fifo_level       = level_q;
    assign snn_input_spikes = spikes_q;
    assign snn_enable       = (state_q == ISSUE);
    assign busy             = (state_q != IDLE);
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_snn_spike_scheduler.sv
// tb/tb_snn_spike_scheduler.sv - directed self-checking bench for snn_spike_scheduler

module tb_snn_spike_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        delay_clk = 1'b0;
    logic        run = 1'b0;
    logic        clear_counts = 1'b0;
    logic [15:0] snn_input_spikes;
    logic        snn_enable;
    logic [1:0]  snn_output_spikes = '0;
    logic [15:0] spike_counts;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    snn_spike_scheduler dut (
        .system_clock      (clk),
        .reset             (reset),
        .frame_in          (frame_in),
        .frame_valid       (frame_valid),
        .frame_ready       (frame_ready),
        .delay_clk         (delay_clk),
        .run               (run),
        .clear_counts      (clear_counts),
        .snn_input_spikes  (snn_input_spikes),
        .snn_enable        (snn_enable),
        .snn_output_spikes (snn_output_spikes),
        .spike_counts      (spike_counts),
        .fifo_level        (fifo_level),
        .busy              (busy),
        .underrun          (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One delay_clk rising edge; captures the ISSUE-cycle view and the cycle after it.
    task automatic tick_pulse(output logic en, output logic [15:0] sp,
                              output logic [2:0] lvl, output logic en_next);
        delay_clk = 1'b1;
        cyc();
        en  = snn_enable;
        sp  = snn_input_spikes;
        lvl = fifo_level;
        delay_clk = 1'b0;
        cyc();
        en_next = snn_enable;
        cyc();
    endtask

    task automatic push(input logic [15:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        cyc();
        frame_valid = 1'b0;
    endtask

    logic        en, en2;
    logic [15:0] sp;
    logic [2:0]  lvl;
    logic [15:0] hold_exp;

    initial begin
        // reset state
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_ready", frame_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_enable", snn_enable, 0);
        chk("rst_spikes", snn_input_spikes, 0);
        chk("rst_counts", spike_counts, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", busy, 0);

        // basic issue of two frames
        push(16'h00A5);
        push(16'h5A00);
        chk("t1_level2", fifo_level, 2);
        run = 1'b1;
        cyc();
        chk("t1_busy", busy, 1);
        tick_pulse(en, sp, lvl, en2);
        chk("t1_en_a", en, 1);
        chk("t1_sp_a", sp, 16'h00A5);
        chk("t1_lvl_a", lvl, 1);
        chk("t1_no_double", en2, 0);
        tick_pulse(en, sp, lvl, en2);
        chk("t1_en_b", en, 1);
        chk("t1_sp_b", sp, 16'h5A00);
        chk("t1_lvl_b", lvl, 0);
        chk("t1_underrun0", underrun, 0);
        chk("t1_held", snn_input_spikes, 16'h5A00);

        // underrun
`ifdef SCHED_UNDERRUN_HOLD_EN
        hold_exp = 16'h5A00;
`else
        hold_exp = 16'h0000;
`endif
        tick_pulse(en, sp, lvl, en2);
        chk("ur_en", en, 1);
        chk("ur_sp", sp, hold_exp);
        chk("ur_flag", underrun, 1);
        clear_counts = 1'b1;
        cyc();
        clear_counts = 1'b0;
        chk("ur_cleared", underrun, 0);

        // fill to full with run=0, fifth frame dropped
        run = 1'b0;
        cyc();
        chk("t2_idle", busy, 0);
        for (int i = 0; i < 5; i++) begin
            push(16'(i + 1));
            if (i == 3) begin
                chk("t2_ready_full", frame_ready, 0);
                chk("t2_level4", fifo_level, 4);
            end
        end
        chk("t2_level_after5", fifo_level, 4);
        tick_pulse(en, sp, lvl, en2);
        chk("t2_idle_tick_ignored", en, 0);
        chk("t2_idle_level", fifo_level, 4);
        run = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            tick_pulse(en, sp, lvl, en2);
            chk("t2_order", sp, 16'(i + 1));
        end
        chk("t2_drained", fifo_level, 0);
        chk("t2_no_underrun", underrun, 0);

        // simultaneous push/pop at level 2, pointer wrap over 10 frames
        push(16'h0100);
        push(16'h0101);
        chk("t3_level2", fifo_level, 2);
        for (int i = 0; i < 8; i++) begin
            frame_in    = 16'h0102 + 16'(i);
            frame_valid = 1'b1;
            delay_clk   = 1'b1;
            cyc();
            frame_valid = 1'b0;
            chk("t3_en", snn_enable, 1);
            chk("t3_sp", snn_input_spikes, 16'h0100 + 16'(i));
            chk("t3_level", fifo_level, 2);
            delay_clk = 1'b0;
            cyc();
            cyc();
        end
        for (int i = 8; i < 10; i++) begin
            tick_pulse(en, sp, lvl, en2);
            chk("t3_drain", sp, 16'h0100 + 16'(i));
        end
        chk("t3_empty", fifo_level, 0);
        chk("t3_no_underrun", underrun, 0);
        chk("t3_counts0", spike_counts, 0);

        // first tick after IDLE does not sample
        snn_output_spikes = 2'b01;
        run = 1'b0;
        cyc();
        run = 1'b1;
        cyc();
        tick_pulse(en, sp, lvl, en2);
        chk("t4_first_tick", spike_counts, 0);

        // saturation
        for (int i = 0; i < 300; i++) begin
            tick_pulse(en, sp, lvl, en2);
            if (i == 9) chk("t4_count10", spike_counts, 16'h000A);
        end
        chk("t4_sat_n0", spike_counts[7:0], 8'hFF);
        chk("t4_sat_n1", spike_counts[15:8], 8'h00);

        // clear coinciding with a sampling tick
        clear_counts = 1'b1;
        delay_clk    = 1'b1;
        cyc();
        clear_counts = 1'b0;
        chk("t4_clear_wins", spike_counts, 0);
        delay_clk = 1'b0;
        cyc();
        cyc();
        tick_pulse(en, sp, lvl, en2);
        chk("t4_resume", spike_counts, 16'h0001);
        snn_output_spikes = 2'b00;

        // reset in the ISSUE cycle with 3 frames queued
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        chk("t5_level3", fifo_level, 3);
        delay_clk = 1'b1;
        cyc();
        chk("t5_issue", snn_enable, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        delay_clk = 1'b0;
        chk("t5_en", snn_enable, 0);
        chk("t5_sp", snn_input_spikes, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_ready", frame_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_counts", spike_counts, 0);
        chk("t5_underrun", underrun, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_no_pulse", snn_enable, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_spike_scheduler.md
Name: snn_spike_scheduler

Overview:
- Sequences input spike frames into the SNN core, one frame per delay-clock timestep.
- Buffers frames from the SPI-side loader in a small FIFO.
- Issues each frame with a one-cycle enable pulse and accumulates per-neuron output spike counts.
- Sits between the synchronized SPI outputs, the clock divider's delay_clk and the SNN core, all in the system_clock domain.

Parameters:
- FRAME_W, 16, width of one input spike frame (one bit per input neuron)
- DEPTH, 4, FIFO depth in frames (power of two, at least 2)
- OUT_N, 2, number of output neurons counted
- CNT_W, 8, width of each output spike counter

Ports:
- system_clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- frame_in  in  FRAME_W  spike frame to enqueue
- frame_valid  in  1  frame_in valid this cycle
- frame_ready  out  1  FIFO can accept a frame (not full)
- delay_clk  in  1  timestep clock from clock divider, generated from system_clock
- run  in  1  scheduler enabled
- clear_counts  in  1  one-cycle pulse that zeroes counters and the underrun flag
- snn_input_spikes  out  FRAME_W  frame presented to the SNN core
- snn_enable  out  1  one-cycle issue pulse to the SNN core
- snn_output_spikes  in  OUT_N  output spikes from the SNN core
- spike_counts  out  OUT_N*CNT_W  saturating per-neuron counts; neuron i occupies bits [i*CNT_W +: CNT_W]
- fifo_level  out  $clog2(DEPTH)+1  frames currently queued
- busy  out  1  state is not IDLE
- underrun  out  1  sticky: a tick occurred with an empty FIFO while run=1

Behaviour:
- Reset (synchronous, active-high): all of the following clear in the next cycle and take priority over all other activity, including mid-issue.
  - FIFO pointers zero, fifo_level=0, frame_ready=1.
  - snn_input_spikes=0, snn_enable=0, spike_counts=0, underrun=0.
  - Edge register=0, state=IDLE.
- Tick detection: delay_clk is registered once (dq).
  - tick = delay_clk & ~dq, combinational, high for exactly one system_clock cycle per delay_clk rising edge.
  - delay_clk is synchronous to system_clock, so no synchronizer is used.
- FIFO:
  - Push when frame_valid & frame_ready.
  - Pop only in ISSUE when not empty.
  - Simultaneous push and pop: level unchanged, both accepted.
  - Push while full is ignored (frame_ready=0).
  - Pointers wrap modulo DEPTH.
- States:
  - IDLE: entered from reset or when run=0. Ticks are ignored. Go to ARMED when run=1.
  - ARMED: wait for tick. On tick, go to ISSUE.
    - Before the transition, sample snn_output_spikes into the counters: each counter increments by 1 where its bit is set and saturates at all-ones.
    - Samples are taken only from the tick that follows an issue. The first tick after entering ARMED from IDLE does not count.
  - ISSUE (one cycle):
    - FIFO not empty: snn_input_spikes <= head, pop.
    - FIFO empty: snn_input_spikes <= 0 and underrun <= 1.
    - snn_enable=1 in this cycle in both cases.
    - Next state is ARMED, or IDLE if run=0.
  - Issue latency: tick detected in cycle T, snn_enable high in cycle T+1, snn_input_spikes valid from T+1 and held until the next ISSUE.
- run dropped in ARMED: go to IDLE next cycle; the FIFO and counters are retained.
- clear_counts: zeroes counters and underrun next cycle. If it coincides with a sampling tick, the clear wins.
- snn_enable never asserts outside ISSUE and never for 2 consecutive cycles.

Optional Feature:
- Macro: SCHED_UNDERRUN_HOLD_EN.
- Defined: on underrun, ISSUE re-presents the last issued frame (held register) instead of zeros. underrun is still set and snn_enable still pulses.
- Undefined: an underrun frame is all-zero, as described above.

Test Plan:
- Reset, push 0x00A5 then 0x5A00, run=1, two delay_clk edges.
  - First tick at T: snn_enable at T+1 with snn_input_spikes=0x00A5.
  - Second tick: 0x5A00.
  - fifo_level 2 -> 1 -> 0, underrun=0.
- Push 5 frames with DEPTH=4 and run=0.
  - frame_ready drops after the 4th push, fifo_level=4, the 5th frame is dropped.
  - Subsequent issues output frames 1-4 in order.
- Push and pop in the same cycle at fifo_level=2.
  - fifo_level stays 2.
  - Pointer wrap verified over 10 frames with no loss or reordering.
- Empty FIFO, run=1, tick.
  - snn_enable pulses, snn_input_spikes=0, underrun=1.
  - With SCHED_UNDERRUN_HOLD_EN: the previous frame is re-presented.
  - clear_counts clears underrun.
- Hold snn_output_spikes=2'b01 across 300 ticks.
  - Neuron-0 count saturates at 255, neuron-1 count stays 0.
  - clear_counts on a sampling tick yields 0.
- Assert reset during the ISSUE cycle with 3 frames queued.
  - Next cycle: all outputs 0, fifo_level=0, state IDLE.
  - No enable pulse follows.
